// File: rtl/imm_encoder_2w_if.sv
// Beat-level valid/ready bundle for the dual-lane immediate encoder.
// The slave modport is the encoder's view of the bundle.
interface imm_encoder_2w_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_slot_vld;
    logic [2:0]           in_imm_src_0;
    logic [2:0]           in_imm_src_1;
    logic [31:0]          in_imm_0;
    logic [31:0]          in_imm_1;
    logic [24:0]          in_base_0;
    logic [24:0]          in_base_1;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_slot_vld;
    logic [24:0]          out_instr_0;
    logic [24:0]          out_instr_1;
    logic                 out_err_0;
    logic                 out_err_1;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_slot_vld,
        output in_imm_src_0, in_imm_src_1,
        output in_imm_0, in_imm_1,
        output in_base_0, in_base_1,
        output out_ready,
        input  in_ready, out_valid, out_slot_vld,
        input  out_instr_0, out_instr_1,
        input  out_err_0, out_err_1, err_cnt
    );

    modport slave (
        input  in_valid, in_slot_vld,
        input  in_imm_src_0, in_imm_src_1,
        input  in_imm_0, in_imm_1,
        input  in_base_0, in_base_1,
        input  out_ready,
        output in_ready, out_valid, out_slot_vld,
        output out_instr_0, out_instr_1,
        output out_err_0, out_err_1, err_cnt
    );
endinterface

// File: rtl/imm_encoder_2w.sv
// Dual-lane RV32 I/S/B/J/U immediate encoder with a main + skid output stage.
// Define IMM_ENC_RANGE_CHK_EN to build representability checks and err_cnt.
module imm_encoder_2w #(
    parameter int ERR_CNT_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    imm_encoder_2w_if.slave bus
);

    typedef struct packed {
        logic [1:0]  vld;
        logic [24:0] instr0;
        logic [24:0] instr1;
        logic        err0;
        logic        err1;
    } beat_t;

    // Result bit k is instruction bit k+7.
    function automatic logic [24:0] enc_imm(
        input logic [2:0]  src,
        input logic [31:0] imm,
        input logic [24:0] base
    );
        logic [24:0] r;
        r = base;
        case (src)
            3'b000: r[24:13] = imm[11:0];
            3'b001: begin
                r[24:18] = imm[11:5];
                r[4:0]   = imm[4:0];
            end
            3'b010: begin
                r[24]    = imm[12];
                r[23:18] = imm[10:5];
                r[4:1]   = imm[4:1];
                r[0]     = imm[11];
            end
            3'b011: begin
                r[24]    = imm[20];
                r[23:14] = imm[10:1];
                r[13]    = imm[11];
                r[12:5]  = imm[19:12];
            end
            3'b100: r[24:5] = imm[31:12];
            default: ;
        endcase
        return r;
    endfunction

`ifdef IMM_ENC_RANGE_CHK_EN
    // A range fits when all bits above the field are copies of its sign.
    function automatic logic bad_imm(
        input logic [2:0]  src,
        input logic [31:0] imm
    );
        logic b;
        case (src)
            3'b000, 3'b001:
                b = !(&imm[31:11] || !(|imm[31:11]));
            3'b010:
                b = !(&imm[31:12] || !(|imm[31:12])) || imm[0];
            3'b011:
                b = !(&imm[31:20] || !(|imm[31:20])) || imm[0];
            3'b100:
                b = |imm[11:0];
            default:
                b = 1'b1;
        endcase
        return b;
    endfunction
`endif

    beat_t nxt;
    beat_t main_q;
    beat_t skid_q;
    logic  main_v;
    logic  skid_v;
    logic  rdy_q;
    logic  in_fire;
    logic  main_free;
    logic  skid_v_n;

    always_comb begin
        nxt.vld    = bus.in_slot_vld;
        nxt.instr0 = enc_imm(bus.in_imm_src_0,
                             bus.in_imm_0, bus.in_base_0);
        nxt.instr1 = enc_imm(bus.in_imm_src_1,
                             bus.in_imm_1, bus.in_base_1);
`ifdef IMM_ENC_RANGE_CHK_EN
        nxt.err0 = bus.in_slot_vld[0]
                 & bad_imm(bus.in_imm_src_0, bus.in_imm_0);
        nxt.err1 = bus.in_slot_vld[1]
                 & bad_imm(bus.in_imm_src_1, bus.in_imm_1);
`else
        nxt.err0 = 1'b0;
        nxt.err1 = 1'b0;
`endif
    end

    // in_ready mirrors skid emptiness, so skid and input never both load.
    assign in_fire   = bus.in_valid & rdy_q;
    assign main_free = !main_v | bus.out_ready;
    assign skid_v_n  = main_free ? 1'b0 : (skid_v | in_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            main_q <= '0;
            skid_v <= 1'b0;
            skid_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            if (main_free) begin
                main_v <= skid_v | in_fire;
                if (skid_v) begin
                    main_q <= skid_q;
                end else if (in_fire) begin
                    main_q <= nxt;
                end
            end else if (in_fire && !skid_v) begin
                skid_q <= nxt;
            end
            skid_v <= skid_v_n;
            rdy_q  <= !skid_v_n;
        end
    end

    assign bus.in_ready     = rdy_q;
    assign bus.out_valid    = main_v;
    assign bus.out_slot_vld = main_q.vld;
    assign bus.out_instr_0  = main_q.instr0;
    assign bus.out_instr_1  = main_q.instr1;
    assign bus.out_err_0    = main_q.err0;
    assign bus.out_err_1    = main_q.err1;

`ifdef IMM_ENC_RANGE_CHK_EN
    logic [ERR_CNT_W-1:0] cnt_q;
    logic [1:0]           add;
    logic [ERR_CNT_W:0]   sum;

    assign add = {1'b0, main_q.err0 & main_q.vld[0]}
               + {1'b0, main_q.err1 & main_q.vld[1]};
    assign sum = {1'b0, cnt_q}
               + {{(ERR_CNT_W-1){1'b0}}, add};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (main_v && bus.out_ready) begin
            cnt_q <= sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
        end
    end

    assign bus.err_cnt = cnt_q;
`else
    assign bus.err_cnt = '0;
`endif

endmodule
